// File: rtl/wino_tile_engine.sv
// -----------------------------------------------------------------------------
// wino_tile_engine
//   Winograd F(2x2,3x3) tile engine. Each accepted beat carries one 4x4 data
//   tile and one 3x3 filter for a single input channel. Both are transformed,
//   multiplied element-wise and accumulated over n channels. The output
//   transform then produces one 2x2 output tile, held until it is taken.
//
// Ports
//   clk       rising-edge clock
//   rstn      asynchronous active-low reset
//   cfg_ch    channels per tile, sampled on the first beat of a tile
//   s_valid   input beat valid
//   s_ready   input beat accepted (registered)
//   s_data    4x4 data tile, elem(r,c) at [(4r+c)*W +: W], signed
//   s_filter  3x3 filter, elem(r,c) at [(3r+c)*W +: W], signed
//   m_valid   output tile valid
//   m_ready   output tile accepted downstream
//   m_y       2x2 output tile, elem(r,c) at [(2r+c)*Y_W +: Y_W], signed
//   busy      engine is not idle
// -----------------------------------------------------------------------------
module wino_tile_engine #(
   parameter int W      = 8,
   parameter int MAX_CH = 16,
   localparam int CH_W  = $clog2(MAX_CH + 1),
   localparam int V_W   = W + 2,
   localparam int U_W   = W + 4,
   localparam int P_W   = 2 * W + 6,
   localparam int ACC_W = P_W + $clog2(MAX_CH),
   localparam int Y_W   = ACC_W + 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [CH_W-1:0]      cfg_ch,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [16*W-1:0]      s_data,
   input  logic [9*W-1:0]       s_filter,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [4*Y_W-1:0]     m_y,
   output logic                 busy
);

   // Working width of the output transform before the final >>> 2.
   localparam int Z_W = ACC_W + 4;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

   state_t                  state_q, state_d;
   logic [CH_W-1:0]         ch_cnt_q, ch_cnt_d;
   logic [CH_W-1:0]         n_q, n_d;
   logic [CH_W-1:0]         n_sel;
   logic                    rdy_q, rdy_d;
   logic                    accept, beat_first, beat_last, y_load;

   logic                    s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
   logic                    s2_vld_q, s2_vld_d, s2_first_q, s2_first_d, s2_last_q, s2_last_d;
   logic                    s3_last_q, s3_last_d, done_q, done_d;

   logic signed [W-1:0]     d_el [16];
   logic signed [W-1:0]     g_el [9];
   logic signed [V_W-1:0]   bt   [16];
   logic signed [U_W-1:0]   hg   [12];
   logic signed [V_W-1:0]   v_q  [16], v_d [16];
   logic signed [U_W-1:0]   u_q  [16], u_d [16];
   logic signed [P_W-1:0]   p_q  [16], p_d [16];
   logic signed [ACC_W-1:0] acc_q[16], acc_d[16];
   logic signed [Z_W-1:0]   at   [8];
   logic signed [Z_W-1:0]   ys   [4];
   logic signed [Y_W-1:0]   y_q  [4], y_d [4];

   for (genvar gi = 0; gi < 16; gi++) begin : g_unpack_d
      assign d_el[gi] = s_data[gi*W +: W];
   end
   for (genvar gi = 0; gi < 9; gi++) begin : g_unpack_g
      assign g_el[gi] = s_filter[gi*W +: W];
   end
   for (genvar gi = 0; gi < 4; gi++) begin : g_pack_y
      assign m_y[gi*Y_W +: Y_W] = y_q[gi];
   end

   assign s_ready = rdy_q;
   assign m_valid = (state_q == OUT);
   assign busy    = (state_q != IDLE);
   assign accept  = s_valid & rdy_q;

   // Channel count for a new tile: 0 means one channel, oversize clamps.
   always_comb begin
      if (cfg_ch == '0)
         n_sel = CH_W'(1);
      else if (cfg_ch > CH_W'(MAX_CH))
         n_sel = CH_W'(MAX_CH);
      else
         n_sel = cfg_ch;
   end

   always_comb begin
      state_d    = state_q;
      ch_cnt_d   = ch_cnt_q;
      n_d        = n_q;
      beat_first = 1'b0;
      beat_last  = 1'b0;
      y_load     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               beat_first = 1'b1;
               ch_cnt_d   = CH_W'(1);
               n_d        = n_sel;
               if (n_sel == CH_W'(1)) begin
                  beat_last = 1'b1;
                  state_d   = DRAIN;
               end else begin
                  state_d   = ACCUM;
               end
            end
         end
         ACCUM: begin
            if (accept) begin
               ch_cnt_d = ch_cnt_q + CH_W'(1);
               if (ch_cnt_q + CH_W'(1) == n_q) begin
                  beat_last = 1'b1;
                  state_d   = DRAIN;
               end
            end
         end
         DRAIN: begin
            // done_q marks the cycle after the last product entered ACC.
            if (done_q) begin
               y_load  = 1'b1;
               state_d = OUT;
            end
         end
         OUT: begin
            if (m_ready) begin
               state_d  = IDLE;
               ch_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      rdy_d = (state_d == IDLE) || (state_d == ACCUM);
   end

   // Pipeline tags travel alongside the data so the accumulator can be
   // overwritten by the first channel of a tile instead of cleared separately.
   always_comb begin
      s1_vld_d   = accept;
      s1_first_d = beat_first;
      s1_last_d  = beat_last;
      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s3_last_d  = s2_vld_q & s2_last_q;
      done_d     = s3_last_q;
   end

   // S1: V = B^T d B and U = (2G) g (2G)^T.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         bt[c]      = V_W'(d_el[c])     - V_W'(d_el[8+c]);
         bt[4+c]    = V_W'(d_el[4+c])   + V_W'(d_el[8+c]);
         bt[8+c]    = V_W'(d_el[8+c])   - V_W'(d_el[4+c]);
         bt[12+c]   = V_W'(d_el[4+c])   - V_W'(d_el[12+c]);
      end
      for (int r = 0; r < 4; r++) begin
         v_d[4*r]   = bt[4*r]   - bt[4*r+2];
         v_d[4*r+1] = bt[4*r+1] + bt[4*r+2];
         v_d[4*r+2] = bt[4*r+2] - bt[4*r+1];
         v_d[4*r+3] = bt[4*r+1] - bt[4*r+3];
      end
      for (int c = 0; c < 3; c++) begin
         hg[c]      = U_W'(g_el[c]) + U_W'(g_el[c]);
         hg[3+c]    = U_W'(g_el[c]) + U_W'(g_el[3+c]) + U_W'(g_el[6+c]);
         hg[6+c]    = U_W'(g_el[c]) - U_W'(g_el[3+c]) + U_W'(g_el[6+c]);
         hg[9+c]    = U_W'(g_el[6+c]) + U_W'(g_el[6+c]);
      end
      for (int r = 0; r < 4; r++) begin
         u_d[4*r]   = hg[3*r] + hg[3*r];
         u_d[4*r+1] = hg[3*r] + hg[3*r+1] + hg[3*r+2];
         u_d[4*r+2] = hg[3*r] - hg[3*r+1] + hg[3*r+2];
         u_d[4*r+3] = hg[3*r+2] + hg[3*r+2];
      end
   end

   // S2 multiply and S3 accumulate.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         p_d[i]   = P_W'(u_q[i]) * P_W'(v_q[i]);
         acc_d[i] = acc_q[i];
         if (s2_vld_q)
            acc_d[i] = s2_first_q ? ACC_W'(p_q[i]) : acc_q[i] + ACC_W'(p_q[i]);
      end
   end

   // S4: Y = (A^T ACC A) >>> 2; the shift removes the 4x scale of U exactly.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         at[j]   = Z_W'(acc_q[j])   + Z_W'(acc_q[4+j]) + Z_W'(acc_q[8+j]);
         at[4+j] = Z_W'(acc_q[4+j]) - Z_W'(acc_q[8+j]) - Z_W'(acc_q[12+j]);
      end
      for (int r = 0; r < 2; r++) begin
         ys[2*r]   = at[4*r]   + at[4*r+1] + at[4*r+2];
         ys[2*r+1] = at[4*r+1] - at[4*r+2] - at[4*r+3];
      end
      for (int k = 0; k < 4; k++)
         y_d[k] = y_load ? Y_W'(ys[k] >>> 2) : y_q[k];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         ch_cnt_q   <= '0;
         n_q        <= '0;
         rdy_q      <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         s3_last_q  <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            v_q[i]   <= '0;
            u_q[i]   <= '0;
            p_q[i]   <= '0;
            acc_q[i] <= '0;
         end
         for (int k = 0; k < 4; k++)
            y_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         ch_cnt_q   <= ch_cnt_d;
         n_q        <= n_d;
         rdy_q      <= rdy_d;
         s1_vld_q   <= s1_vld_d;
         s1_first_q <= s1_first_d;
         s1_last_q  <= s1_last_d;
         s2_vld_q   <= s2_vld_d;
         s2_first_q <= s2_first_d;
         s2_last_q  <= s2_last_d;
         s3_last_q  <= s3_last_d;
         done_q     <= done_d;
         for (int i = 0; i < 16; i++) begin
            v_q[i]   <= v_d[i];
            u_q[i]   <= u_d[i];
            p_q[i]   <= p_d[i];
            acc_q[i] <= acc_d[i];
         end
         for (int k = 0; k < 4; k++)
            y_q[k] <= y_d[k];
      end
   end

endmodule

// File: tb/tb_wino_tile_engine.sv
// -----------------------------------------------------------------------------
// tb_wino_tile_engine
//   Randomised bench for wino_tile_engine. The reference is a direct 3x3
//   valid convolution of each data tile with its filter, summed over the
//   accepted channels.
// -----------------------------------------------------------------------------
module tb_wino_tile_engine;

   localparam int W      = 8;
   localparam int MAX_CH = 16;
   localparam int CH_W   = 5;
   localparam int Y_W    = 28;

   logic              clk = 1'b0;
   logic              rstn = 1'b1;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [16*W-1:0]   s_data = '0;
   logic [9*W-1:0]    s_filter = '0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [4*Y_W-1:0]  m_y;
   logic              busy;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint ref_y [4];

   logic [16*W-1:0] t1_data = 128'h04040404030303030202020201010101;
   logic [9*W-1:0]  t1_filt = 72'h090807060504030201;

   wino_tile_engine #(.W(W), .MAX_CH(MAX_CH)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .cfg_ch   (cfg_ch),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .s_filter (s_filter),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_y      (m_y),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Direct convolution: y(i,j) += sum g(a,b) * d(i+a, j+b).
   task automatic add_ref(input logic [16*W-1:0] dt, input logic [9*W-1:0] ft);
      longint gv, dv;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++)
            for (int a = 0; a < 3; a++)
               for (int b = 0; b < 3; b++) begin
                  gv = $signed(ft[(3*a+b)*W +: W]);
                  dv = $signed(dt[(4*(i+a)+(j+b))*W +: W]);
                  ref_y[2*i+j] += gv * dv;
               end
   endtask

   function automatic longint y_at(input int k);
      logic signed [Y_W-1:0] v;
      v = m_y[k*Y_W +: Y_W];
      return longint'(v);
   endfunction

   // Streams one tile in the given data mode (0 random, 1 fixed example,
   // 2 all -1 data with unit filter) until s_ready drops after an accept.
   task automatic stream_tile(input int cfg, input int mode, input int bubble_after,
                              output int beats);
      logic [16*W-1:0] dt;
      logic [9*W-1:0]  ft;
      logic [95:0]     r96;
      int              guard;
      for (int k = 0; k < 4; k++) ref_y[k] = 0;
      beats  = 0;
      cfg_ch = CH_W'(cfg);
      while (beats < 40) begin
         case (mode)
            1: begin dt = t1_data; ft = t1_filt; end
            2: begin dt = '1; ft = {9{8'h01}}; end
            default: begin
               dt  = {$urandom(), $urandom(), $urandom(), $urandom()};
               r96 = {$urandom(), $urandom(), $urandom()};
               ft  = r96[71:0];
            end
         endcase
         if (bubble_after > 0 && beats == bubble_after) begin
            s_valid = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            n_checks++;
            if (s_ready !== 1'b1 || busy !== 1'b1) begin
               n_fail++;
               $display("FAIL bubble_ready: s_ready=%0b busy=%0b required 1/1", s_ready, busy);
            end
         end
         s_data   = dt;
         s_filter = ft;
         s_valid  = 1'b1;
         guard    = 0;
         @(negedge clk);
         while (s_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (s_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: s_ready=%0b required 1 within 20 cycles", s_ready);
            s_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         beats++;
         add_ref(dt, ft);
         cfg_ch = CH_W'($urandom_range(0, 31));
         if (s_ready !== 1'b1) break;
      end
      s_valid = 1'b0;
   endtask

   // Waits for the output tile, compares it with the model, optionally holds
   // m_ready low for `hold` cycles, then completes the handshake.
   task automatic get_output(input string name, input int hold);
      int               guard;
      longint           got;
      logic [4*Y_W-1:0] first;
      guard = 0;
      @(negedge clk);
      while (m_valid !== 1'b1 && guard < 30) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (m_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_timeout: m_valid=%0b required 1 within 30 cycles", name, m_valid);
         return;
      end
      for (int k = 0; k < 4; k++) begin
         got = y_at(k);
         n_checks++;
         if (got !== ref_y[k]) begin
            n_fail++;
            $display("FAIL %s_y%0d: got %0d required %0d", name, k, got, ref_y[k]);
         end
      end
      $display("tile %s: y = %0d %0d %0d %0d", name, y_at(0), y_at(1), y_at(2), y_at(3));
      first = m_y;
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         n_checks++;
         if (m_y !== first || m_valid !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold: m_y=%h m_valid=%0b s_ready=%0b required %h/1/0",
                     name, m_y, m_valid, s_ready, first);
         end
      end
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      n_checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_handshake: m_valid=%0b busy=%0b s_ready=%0b required 0/0/1",
                  name, m_valid, busy, s_ready);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      n_checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0 || m_y !== '0) begin
         n_fail++;
         $display("FAIL %s: s_ready=%0b m_valid=%0b busy=%0b m_y=%h required all zero",
                  name, s_ready, m_valid, busy, m_y);
      end
   endtask

   task automatic check_beats(input string name, input int got, input int req);
      n_checks++;
      if (got != req) begin
         n_fail++;
         $display("FAIL %s_beats: accepted %0d required %0d", name, got, req);
      end
   endtask

   task automatic test_reset();
      #1 rstn = 1'b0;
      #1 check_reset_outputs("reset_state");
      repeat (2) @(posedge clk);
      #1 check_reset_outputs("reset_held");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (s_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: s_ready=%0b busy=%0b required 1/0", s_ready, busy);
      end
   endtask

   task automatic test_basic();
      int beats;
      stream_tile(1, 1, 0, beats);
      check_beats("basic", beats, 1);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (m_valid !== (k == 4)) begin
            n_fail++;
            $display("FAIL basic_latency: m_valid=%0b at cycle %0d required %0b", m_valid, k, k == 4);
         end
      end
      n_checks++;
      if (y_at(0) != 108 || y_at(1) != 108 || y_at(2) != 153 || y_at(3) != 153) begin
         n_fail++;
         $display("FAIL basic_const: y=%0d %0d %0d %0d required 108 108 153 153",
                  y_at(0), y_at(1), y_at(2), y_at(3));
      end
      get_output("basic", 0);
   endtask

   task automatic test_bubble();
      int beats;
      stream_tile(4, 1, 2, beats);
      check_beats("bubble", beats, 4);
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_drain_ready: s_ready=%0b required 0", s_ready);
         end
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (y_at(0) != 432 || y_at(1) != 432 || y_at(2) != 612 || y_at(3) != 612) begin
         n_fail++;
         $display("FAIL bubble_const: y=%0d %0d %0d %0d required 432 432 612 612",
                  y_at(0), y_at(1), y_at(2), y_at(3));
      end
      get_output("bubble", 0);
   endtask

   task automatic test_negative();
      int beats;
      stream_tile(MAX_CH, 2, 0, beats);
      check_beats("negative", beats, MAX_CH);
      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (y_at(k) != -9 * MAX_CH) begin
            n_fail++;
            $display("FAIL negative_y%0d: got %0d required %0d", k, y_at(k), -9 * MAX_CH);
         end
      end
      get_output("negative", 0);
   endtask

   task automatic test_backpressure();
      int beats;
      stream_tile(3, 0, 0, beats);
      check_beats("backpressure", beats, 3);
      get_output("backpressure", 10);
      stream_tile(2, 0, 0, beats);
      check_beats("after_bp", beats, 2);
      get_output("after_bp", 0);
   endtask

   task automatic test_mid_reset();
      int beats;
      for (int k = 0; k < 4; k++) ref_y[k] = 0;
      cfg_ch   = CH_W'(4);
      s_data   = t1_data;
      s_filter = t1_filt;
      s_valid  = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      s_valid = 1'b0;
      rstn    = 1'b0;
      #1 check_reset_outputs("midreset_now");
      repeat (3) @(posedge clk);
      #3 rstn = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_idle: m_valid=%0b busy=%0b s_ready=%0b required 0/0/1",
                     m_valid, busy, s_ready);
         end
      end
      stream_tile(1, 1, 0, beats);
      check_beats("midreset_next", beats, 1);
      get_output("midreset_next", 0);
   endtask

   task automatic test_cfg_edges();
      int beats;
      stream_tile(0, 0, 0, beats);
      check_beats("cfg_zero", beats, 1);
      get_output("cfg_zero", 0);
      stream_tile(MAX_CH + 3, 0, 0, beats);
      check_beats("cfg_clamp", beats, MAX_CH);
      get_output("cfg_clamp", 0);
   endtask

   task automatic test_back_to_back();
      int beats, cfg, req, bub;
      for (int t = 0; t < 6; t++) begin
         cfg = $urandom_range(1, MAX_CH + 2);
         req = (cfg > MAX_CH) ? MAX_CH : cfg;
         bub = (req > 1) ? $urandom_range(0, req - 1) : 0;
         stream_tile(cfg, 0, bub, beats);
         check_beats("b2b", beats, req);
         get_output("b2b", $urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubble();
      test_negative();
      test_backpressure();
      test_mid_reset();
      test_cfg_edges();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
